// File: rtl/forwarding_hazard_unit.sv
// forwarding_hazard_unit: operand forwarding selects, RAW/load-use stall and saturating stall counter
module forwarding_hazard_unit #(
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic             id_uses_src1,
    input  logic [3:0]       id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             flush,
    output logic             hazard,
    output logic [1:0]       sel_src1,
    output logic [1:0]       sel_src2,
    output logic [CNT_W-1:0] stall_count
);
    logic [3:0] exe_dest, mem_dest;
    logic       exe_wb, exe_ld, mem_wb;
    logic       rd1, rd2, me1, me2, mm1, mm2, adv;

    assign rd1 = id_valid & id_uses_src1;
    assign rd2 = id_valid & id_two_src;
    assign me1 = rd1 & exe_wb & (exe_dest == id_src1);
    assign me2 = rd2 & exe_wb & (exe_dest == id_src2);
    assign mm1 = rd1 & mem_wb & (mem_dest == id_src1);
    assign mm2 = rd2 & mem_wb & (mem_dest == id_src2);
    // A flushed ID instruction is discarded, so it can never stall.
    assign hazard = ~flush & ((FWD_EN != 0) ? ((me1 | me2) & exe_ld) : (me1 | me2 | mm1 | mm2));
    assign adv = id_valid & ~hazard & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_dest    <= 4'd0;
            exe_wb      <= 1'b0;
            exe_ld      <= 1'b0;
            mem_dest    <= 4'd0;
            mem_wb      <= 1'b0;
            sel_src1    <= 2'd0;
            sel_src2    <= 2'd0;
            stall_count <= '0;
        end else begin
            mem_dest <= exe_dest;
            mem_wb   <= exe_wb;
            exe_dest <= adv ? id_dest : 4'd0;
            exe_wb   <= adv & id_wb_en;
            exe_ld   <= adv & id_mem_r_en;
            sel_src1 <= (adv && FWD_EN != 0) ? (me1 ? 2'd1 : mm1 ? 2'd2 : 2'd0) : 2'd0;
            sel_src2 <= (adv && FWD_EN != 0) ? (me2 ? 2'd1 : mm2 ? 2'd2 : 2'd0) : 2'd0;
            if (hazard && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// tb_forwarding_hazard_unit: scoreboard bench for forwarding and non-forwarding builds side by side
module tb_forwarding_hazard_unit;
    localparam int CW = 4;
    localparam int NRAND = 3000;

    typedef struct packed {
        logic       rst, flush, valid, uses1, two, wb, ld;
        logic [3:0] src1, src2, dest;
    } stim_t;

    typedef struct packed {
        logic       wb, ld;
        logic [3:0] dest;
    } slot_t;

    typedef struct packed {
        logic          h0, h1;
        logic [1:0]    a0, b0, a1, b1;
        logic [CW-1:0] c0, c1;
    } exp_t;

    logic clk = 1'b0;
    logic rst, id_valid, id_two_src, id_uses_src1, id_wb_en, id_mem_r_en, flush;
    logic [3:0] id_src1, id_src2, id_dest;
    logic hz_f, hz_n;
    logic [1:0] s1_f, s2_f, s1_n, s2_n;
    logic [CW-1:0] cnt_f, cnt_n;

    always #5 clk = ~clk;

    forwarding_hazard_unit #(.FWD_EN(1), .CNT_W(CW)) u_f (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_uses_src1(id_uses_src1), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .flush(flush),
        .hazard(hz_f), .sel_src1(s1_f), .sel_src2(s2_f), .stall_count(cnt_f)
    );

    forwarding_hazard_unit #(.FWD_EN(0), .CNT_W(CW)) u_n (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_uses_src1(id_uses_src1), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .flush(flush),
        .hazard(hz_n), .sel_src1(s1_n), .sel_src2(s2_n), .stall_count(cnt_n)
    );

    // Reference: per build, a two-deep list of in-flight producers, index 0 = youngest (EXE).
    slot_t      pipe [2][2];
    logic [1:0] msel [2][2];
    int         mcnt [2];
    exp_t       sb[$];
    stim_t      dq[$];
    int         tests = 0, fails = 0;
    bit         done = 0;

    function automatic stim_t mk(logic v, logic [3:0] s1, logic [3:0] s2, logic two, logic u1,
                                 logic [3:0] d, logic wb, logic ld, logic fl, logic r);
        stim_t s;
        s.valid = v; s.src1 = s1; s.src2 = s2; s.two = two; s.uses1 = u1;
        s.dest = d; s.wb = wb; s.ld = ld; s.flush = fl; s.rst = r;
        return s;
    endfunction

    function automatic logic [1:0] producer(int m, logic rd, logic [3:0] r);
        if (!rd) return 2'd0;
        for (int a = 0; a < 2; a++)
            if (pipe[m][a].wb && pipe[m][a].dest == r) return 2'(a + 1);
        return 2'd0;
    endfunction

    function automatic logic model_haz(int m, stim_t s);
        logic [1:0] p1, p2;
        if (s.flush) return 1'b0;
        p1 = producer(m, s.valid & s.uses1, s.src1);
        p2 = producer(m, s.valid & s.two, s.src2);
        if (m == 0) return (p1 == 2'd1 || p2 == 2'd1) && pipe[m][0].ld;
        return p1 != 2'd0 || p2 != 2'd0;
    endfunction

    task automatic step_model(stim_t s, logic h0, logic h1);
        logic hh, adv;
        slot_t nw;
        for (int m = 0; m < 2; m++) begin
            hh  = (m == 0) ? h0 : h1;
            adv = s.valid && !hh && !s.flush;
            nw.wb = adv & s.wb; nw.ld = adv & s.ld; nw.dest = adv ? s.dest : 4'd0;
            if (s.rst) begin
                pipe[m][0] = '0; pipe[m][1] = '0;
                msel[m][0] = 2'd0; msel[m][1] = 2'd0; mcnt[m] = 0;
            end else begin
                msel[m][0] = (adv && m == 0) ? producer(m, s.valid & s.uses1, s.src1) : 2'd0;
                msel[m][1] = (adv && m == 0) ? producer(m, s.valid & s.two, s.src2) : 2'd0;
                if (hh) mcnt[m] = (mcnt[m] + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : mcnt[m] + 1;
                pipe[m][1] = pipe[m][0];
                pipe[m][0] = nw;
            end
        end
    endtask

    task automatic apply(stim_t s);
        rst = s.rst; flush = s.flush; id_valid = s.valid; id_uses_src1 = s.uses1;
        id_two_src = s.two; id_wb_en = s.wb; id_mem_r_en = s.ld;
        id_src1 = s.src1; id_src2 = s.src2; id_dest = s.dest;
    endtask

    initial begin
        stim_t cur;
        exp_t  e;
        logic  h0, h1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        h0 = 0; h1 = 0;
        for (int m = 0; m < 2; m++) begin
            pipe[m][0] = '0; pipe[m][1] = '0; msel[m][0] = 0; msel[m][1] = 0; mcnt[m] = 0;
        end
        dq.push_back(mk(1, 2, 3, 1, 1, 1, 1, 0, 0, 0));
        dq.push_back(mk(1, 1, 5, 1, 1, 4, 1, 0, 0, 0));
        dq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        dq.push_back(mk(1, 2, 3, 1, 1, 1, 1, 0, 0, 0));
        dq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        dq.push_back(mk(1, 7, 1, 1, 1, 6, 1, 0, 0, 0));
        dq.push_back(mk(1, 8, 0, 0, 1, 2, 1, 1, 0, 0));
        dq.push_back(mk(1, 2, 2, 1, 1, 3, 1, 0, 0, 0));
        dq.push_back(mk(1, 2, 2, 1, 1, 3, 1, 0, 0, 0));
        dq.push_back(mk(1, 2, 3, 1, 1, 1, 1, 0, 0, 0));
        dq.push_back(mk(1, 0, 9, 1, 0, 1, 1, 0, 0, 0));
        dq.push_back(mk(1, 1, 4, 1, 1, 0, 0, 0, 0, 0));
        dq.push_back(mk(1, 8, 0, 0, 1, 2, 1, 1, 0, 0));
        dq.push_back(mk(1, 2, 2, 1, 1, 3, 1, 0, 1, 0));
        dq.push_back(mk(1, 8, 0, 0, 1, 2, 1, 1, 0, 0));
        dq.push_back(mk(1, 2, 2, 1, 1, 3, 1, 0, 0, 0));
        dq.push_back(mk(1, 2, 2, 1, 1, 3, 1, 0, 0, 1));
        dq.push_back(mk(1, 2, 2, 1, 1, 3, 1, 0, 0, 0));
        dq.push_back(mk(1, 15, 15, 1, 1, 15, 1, 0, 0, 0));
        dq.push_back(mk(1, 15, 0, 0, 1, 3, 1, 0, 0, 0));
        @(posedge clk);
        for (int c = 0; c < NRAND; c++) begin
            #1;
            if (dq.size() > 0) cur = dq.pop_front();
            else if (!((h0 || h1) && $urandom_range(0, 3) != 0)) begin
                cur.valid = $urandom_range(0, 7) != 0;
                cur.src1  = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
                cur.src2  = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
                cur.dest  = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
                cur.uses1 = $urandom_range(0, 5) != 0;
                cur.two   = $urandom_range(0, 1);
                cur.wb    = $urandom_range(0, 4) != 0;
                cur.ld    = $urandom_range(0, 2) == 0;
                cur.flush = $urandom_range(0, 15) == 0;
                cur.rst   = $urandom_range(0, 99) == 0;
            end
            apply(cur);
            h0 = model_haz(0, cur);
            h1 = model_haz(1, cur);
            e.h0 = h0; e.a0 = msel[0][0]; e.b0 = msel[0][1]; e.c0 = CW'(mcnt[0]);
            e.h1 = h1; e.a1 = msel[1][0]; e.b1 = msel[1][1]; e.c1 = CW'(mcnt[1]);
            sb.push_back(e);
            step_model(cur, h0, h1);
            @(posedge clk);
        end
        done = 1;
    end

    task automatic chk(string nm, int cyc, logic [7:0] act, logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        int   cyc = 0;
        for (;;) begin
            @(negedge clk);
            if (done && sb.size() == 0) break;
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL scoreboard cycle %0d: got empty queue expected entry", cyc);
                break;
            end
            e = sb.pop_front();
            chk("hazard_fwd", cyc, 8'(hz_f), 8'(e.h0));
            chk("sel1_fwd",   cyc, 8'(s1_f), 8'(e.a0));
            chk("sel2_fwd",   cyc, 8'(s2_f), 8'(e.b0));
            chk("count_fwd",  cyc, 8'(cnt_f), 8'(e.c0));
            chk("hazard_nof", cyc, 8'(hz_n), 8'(e.h1));
            chk("sel1_nof",   cyc, 8'(s1_n), 8'(e.a1));
            chk("sel2_nof",   cyc, 8'(s2_n), 8'(e.b1));
            chk("count_nof",  cyc, 8'(cnt_n), 8'(e.c1));
            cyc++;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/forwarding_hazard_unit.md
Name: forwarding_hazard_unit

Overview:
- Produces the operand-source selects `sel_src1`/`sel_src2` (2'd0 register file, 2'd1 `ALU_result_reg`, 2'd2 `WB_WB_DEST`) and the pipeline stall for the ARM-style 5-stage core.
- Keeps a shadow copy of the destination/write-enable/load info of instructions in EXE and MEM, advanced each clock.
- Registered selects are aligned with the instruction entering EXE on the next cycle.
- Also counts stall cycles for performance measurement.

Parameters:
- FWD_EN, 1, 1 = forwarding enabled; 0 = stall on every RAW hazard and force selects to 2'd0.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- `clk`  input  1  system clock, all state on rising edge
- `rst`  input  1  synchronous, active-high reset
- `id_valid`  input  1  ID holds a real instruction
- `id_src1`  input  4  Rn index of ID instruction
- `id_src2`  input  4  second source index (Rm, or Rd for stores)
- `id_two_src`  input  1  `id_src2` is actually read
- `id_uses_src1`  input  1  `id_src1` is actually read (0 for MOV/MVN/branch)
- `id_dest`  input  4  destination index of ID instruction
- `id_wb_en`  input  1  ID instruction writes a register
- `id_mem_r_en`  input  1  ID instruction is a load
- `flush`  input  1  taken branch in EXE; ID instruction is killed
- `hazard`  output  1  combinational stall for PC/IF-ID; ID/EXE loads a bubble
- `sel_src1`  output  2  registered select for EXE operand 1
- `sel_src2`  output  2  registered select for EXE operand 2
- `stall_count`  output  CNT_W  saturating count of cycles with `hazard`=1

Behaviour:
- Tracking registers:
  - `exe_dest`, `exe_wb`, `exe_ld` describe the instruction now in EXE.
  - `mem_dest`, `mem_wb` describe the instruction now in MEM.
- Per-cycle advance:
  - The MEM copy takes the EXE copy.
  - The EXE copy takes the ID fields if `id_valid & ~hazard & ~flush`; otherwise it becomes a bubble (`exe_wb`=0, `exe_ld`=0, dest 0).
- Match definitions, x in {1,2}:
  - rd_x = `id_valid` & (x==1 ? `id_uses_src1` : `id_two_src`).
  - mE_x = rd_x & `exe_wb` & (`exe_dest` == src_x).
  - mM_x = rd_x & `mem_wb` & (`mem_dest` == src_x).
- `hazard` (combinational):
  - FWD_EN=1: `hazard` = (mE_1 | mE_2) & `exe_ld` (load-use only).
  - FWD_EN=0: `hazard` = mE_1 | mE_2 | mM_1 | mM_2.
  - `hazard` is forced 0 when `flush`=1 (the ID instruction is discarded anyway).
- Select computation, registered on the clock edge:
  - Computed only when the ID instruction advances (`id_valid & ~hazard & ~flush`); otherwise both selects register 2'd0.
  - FWD_EN=1:
    - sel_x = mE_x ? 2'd1 : mM_x ? 2'd2 : 2'd0.
    - EXE match has priority, being the youngest writer.
    - The EXE producer is in MEM next cycle (`ALU_result_reg`); the MEM producer is in WB (`WB_WB_DEST`).
  - FWD_EN=0: selects are always 2'd0.
- Load-use sequence:
  - Cycle n: `hazard`=1 and a bubble enters EXE.
  - Cycle n+1: the load is in MEM, so mM matches, `hazard`=0, and sel = 2'd2.
- Register 15 is treated like any other index; no special casing.
- `stall_count` increments each cycle `hazard`=1 and holds at all-ones (no wrap).
- Reset values: `rst`=1 at a clock edge clears all tracking registers to bubble, `sel_src1`=`sel_src2`=2'd0, `stall_count`=0.
  - `hazard` is 0 in the cycle after reset because the tracking state is empty.
- Reset mid-stall: the stall is abandoned, nothing is forwarded, and the counter returns to 0.
- Flush plus hazard in the same cycle: flush wins. The bubble is inserted, no stall is counted, and the selects are 0.
- Latency: `hazard` has zero cycles of latency; the selects have one cycle.

Test Plan:
- ADD R1 ← R2,R3 then immediately SUB R4 ← R1,R5 (FWD_EN=1) -> `hazard`=0; the cycle SUB enters EXE, `sel_src1`=2'd1 and `sel_src2`=2'd0.
- ADD R1, unrelated NOP, then ORR R6 ← R7,R1 (`two_src`=1) -> `sel_src2`=2'd2 and `sel_src1`=2'd0.
- LDR R2 then ADD R3 ← R2,R2 -> `hazard`=1 for exactly 1 cycle and `stall_count`=1; ADD then enters EXE with `sel_src1`=`sel_src2`=2'd2.
- ADD R1 followed by MOV R1 (both `wb_en`), then CMP R1 -> `sel_src1`=2'd1 (youngest writer wins, not 2'd2).
- FWD_EN=0: ADD R1 then SUB using R1 -> `hazard` high for 2 cycles, then `sel_src1`=2'd0; `stall_count`=2.
- Load-use hazard with `flush`=1 in the same cycle -> `hazard`=0, the EXE copy is a bubble, and `stall_count` is unchanged. Assert `rst` during a stall -> all outputs and `stall_count` read 0 on the next cycle.
